// File: rtl/demux_pkg.sv
// Shared definitions for the demux demo: FSM state encoding and default sizes.
`timescale 1ns/1ps
package demux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_TICK_BIT   = 20;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/demux_scanner_edge_rise.sv
// Single-bit rising-edge detector; history register resets to RESET_VAL so a
// source that idles high under reset does not produce a false edge on release.
`timescale 1ns/1ps
module edge_rise #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= RESET_VAL;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/demux_scanner.sv
// Round-robin slot scanner: one valid/ready fetch per counter tick-bit rising
// edge, written into the next output slot, with a sticky overrun flag.
`timescale 1ns/1ps
module demux_scanner
  import demux_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int TICK_BIT   = DEF_TICK_BIT,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CNT_WIDTH-1:0]           counter_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           data_valid,
  output logic                           data_ready,
  output logic [SEL_WIDTH-1:0]           ch_sel,
  output logic [CHANNELS-1:0]            ch_enable,
  output logic [CHANNELS*DATA_WIDTH-1:0] ch_out,
  output logic [CHANNELS-1:0]            ch_strobe,
  input  logic                           overrun_clr,
  output logic                           overrun
);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [SEL_WIDTH-1:0]           r_sel;
  logic [SEL_WIDTH-1:0]           w_sel_nxt;
  logic [CHANNELS*DATA_WIDTH-1:0] r_out;
  logic [CHANNELS-1:0]            r_strobe;
  logic [CHANNELS-1:0]            w_enable;
  logic                           r_overrun;
  logic                           w_tick;
  logic                           w_hs;
  logic                           w_write;
  logic                           w_adv;
  logic                           w_ovr_set;
  logic                           w_unused;

  // Only the tick bit is observed; the rest of the counter bus is ignored.
  assign w_unused = ^counter_in;

  edge_rise #(.RESET_VAL(1'b1)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_d    (counter_in[TICK_BIT]),
    .o_rise (w_tick)
  );

  assign data_ready = (r_state == FETCH);
  assign w_hs       = data_valid & data_ready;
  assign w_enable   = CHANNELS'(1) << r_sel;
  assign w_sel_nxt  = (r_sel == SEL_WIDTH'(CHANNELS - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_adv       = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) w_state_nxt = FETCH;
      end
      FETCH: begin
        if (w_hs) begin
          w_write = 1'b1;
          w_adv   = 1'b1;
          if (!w_tick) w_state_nxt = IDLE;
        end else if (w_tick) begin
          // Window missed: skip this slot and keep fetching for the next one.
          w_ovr_set = 1'b1;
          w_adv     = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_out     <= '0;
      r_strobe  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_write ? w_enable : '0;
      if (w_adv) r_sel <= w_sel_nxt;
      if (w_write) r_out[r_sel*DATA_WIDTH +: DATA_WIDTH] <= data_in;
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
    end
  end

  assign ch_sel    = r_sel;
  assign ch_enable = w_enable;
  assign ch_out    = r_out;
  assign ch_strobe = r_strobe;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_demux_scanner.sv
// Scoreboard bench for demux_scanner: a fetch-window reference model predicts
// slot writes into a queue; a negedge monitor pops and compares on each strobe.
`timescale 1ns/1ps
module tb_demux_scanner;
  localparam int CW = 8, TB = 2, CH = 4, SW = 2, DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   counter_in;
  logic [DW-1:0]   data_in;
  logic            data_valid;
  logic            data_ready;
  logic [SW-1:0]   ch_sel;
  logic [CH-1:0]   ch_enable;
  logic [CH*DW-1:0] ch_out;
  logic [CH-1:0]   ch_strobe;
  logic            overrun_clr;
  logic            overrun;

  demux_scanner #(
    .CNT_WIDTH(CW), .TICK_BIT(TB), .CHANNELS(CH), .SEL_WIDTH(SW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .counter_in(counter_in), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .ch_sel(ch_sel),
    .ch_enable(ch_enable), .ch_out(ch_out), .ch_strobe(ch_strobe),
    .overrun_clr(overrun_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a fetch window opens on each rising edge of the tick bit;
  // the first accepted word fills the current slot, an unfilled window that is
  // overtaken by a new tick skips its slot and raises overrun.
  typedef struct {
    int          slot;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            order_q[$];
  bit            m_pending, m_ovr, m_prev;
  int            m_sel;
  logic [DW-1:0] m_slots[CH];

  function automatic logic [CH*DW-1:0] m_pack();
    logic [CH*DW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DW +: DW] = m_slots[k];
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit tk, hs, set;
    if (reset) begin
      m_pending = 0;
      m_ovr     = 0;
      m_prev    = 1;
      m_sel     = 0;
      for (int k = 0; k < CH; k++) m_slots[k] = '0;
      exp_q.delete();
    end else begin
      tk     = counter_in[TB] && !m_prev;
      m_prev = counter_in[TB];
      hs     = data_valid && m_pending;
      set    = 0;
      if (hs) begin
        exp_q.push_back('{m_sel, data_in});
        m_slots[m_sel] = data_in;
        m_sel          = (m_sel + 1) % CH;
        m_pending      = tk;
      end else if (tk) begin
        if (m_pending) begin
          set   = 1;
          m_sel = (m_sel + 1) % CH;
        end
        m_pending = 1;
      end
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    wr_t w;
    if (reset) begin
      check("strobe_in_reset", ch_strobe, 0);
    end else begin
      if (ch_strobe != 0) begin
        if (exp_q.size() == 0) check("spurious_strobe", ch_strobe, 0);
        else begin
          w = exp_q.pop_front();
          check("strobe_onehot", ch_strobe, 1 << w.slot);
          check("slot_data", ch_out[w.slot*DW +: DW], w.data);
          order_q.push_back(w.slot);
        end
      end else if (exp_q.size() != 0) begin
        check("missing_strobe", exp_q.size(), 0);
        exp_q.delete();
      end
      check("data_ready", data_ready, m_pending);
      check("ch_sel", ch_sel, m_sel);
      check("ch_enable", ch_enable, 1 << m_sel);
      check("overrun", overrun, m_ovr);
      check("ch_out", ch_out, m_pack());
    end
  end

  task automatic tick_clk();
    @(negedge clk);
    counter_in = counter_in + 1'b1;
  endtask

  // Reset with the counter at all-ones, release while still all-ones, then the
  // counter rolls over to 0 and counts up.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; counter_in = '1; data_valid = 1'b0; overrun_clr = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (data_ready) break;
      tick_clk();
    end
    check("ready_timeout", data_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rr_words[5];
    int            mode;
    reset = 1'b1; counter_in = '1; data_valid = 1'b0; overrun_clr = 1'b0; data_in = '0;

    // Reset release: no tick until the counter reaches 4
    do_reset();
    check("rst_ready", data_ready, 0);
    check("rst_sel", ch_sel, 0);
    check("rst_enable", ch_enable, 4'b0001);
    check("rst_out", ch_out, 0);
    check("rst_overrun", overrun, 0);
    for (int i = 0; i < 20 && counter_in != 8'd4; i++) begin
      tick_clk();
      check("pre_tick_ready", data_ready, 0);
      check("pre_tick_strobe", ch_strobe, 0);
      check("pre_tick_enable", ch_enable, 4'b0001);
    end

    // Basic fetch
    tick_clk();
    check("tick_ready", data_ready, 1);
    data_valid = 1'b1; data_in = 8'hA5;
    tick_clk();
    data_valid = 1'b0;
    check("basic_strobe", ch_strobe, 4'b0001);
    check("basic_slot0", ch_out[7:0], 8'hA5);
    check("basic_sel", ch_sel, 1);
    check("basic_ready_low", data_ready, 0);
    tick_clk();
    check("basic_strobe_one_cycle", ch_strobe, 0);

    // Round-robin wrap
    do_reset();
    order_q.delete();
    rr_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      wait_ready(20);
      data_valid = 1'b1; data_in = rr_words[i];
      tick_clk();
      data_valid = 1'b0;
    end
    tick_clk();
    check("rr_out", ch_out, 32'h4433_2255);
    check("rr_sel", ch_sel, 1);
    check("rr_order_len", order_q.size(), 5);
    for (int i = 0; i < 5 && i < order_q.size(); i++) check("rr_order", order_q[i], i % CH);

    // Overrun: ticks at counts 4 and 12 with no data
    do_reset();
    for (int i = 0; i < 40 && counter_in != 8'd14; i++) tick_clk();
    check("ovr_set", overrun, 1);
    check("ovr_sel", ch_sel, 1);
    check("ovr_slot0", ch_out[7:0], 0);
    check("ovr_ready", data_ready, 1);
    overrun_clr = 1'b1;
    tick_clk();
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Tick and handshake on the same edge
    for (int i = 0; i < 16 && counter_in[2:0] != 3'd4; i++) tick_clk();
    data_valid = 1'b1; data_in = 8'h77;
    tick_clk();
    data_valid = 1'b0;
    check("sim_strobe", ch_strobe, 4'b0010);
    check("sim_slot1", ch_out[15:8], 8'h77);
    check("sim_sel", ch_sel, 2);
    check("sim_ready", data_ready, 1);
    check("sim_overrun", overrun, 0);

    // Reset mid-fetch aborts the pending write
    data_valid = 1'b1; data_in = 8'h99;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", data_ready, 0);
    check("mid_rst_strobe", ch_strobe, 0);
    check("mid_rst_sel", ch_sel, 0);
    check("mid_rst_enable", ch_enable, 4'b0001);
    check("mid_rst_out", ch_out, 0);
    check("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    check("mid_rst_strobe_after", ch_strobe, 0);
    check("mid_rst_out_after", ch_out, 0);

    // Randomized traffic with varying source eagerness
    do_reset();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      tick_clk();
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       data_valid = ($urandom_range(0, 9) == 0);
        1:       data_valid = $urandom_range(0, 1);
        default: data_valid = 1'b1;
      endcase
      data_in     = DW'($urandom);
      overrun_clr = ($urandom_range(0, 15) == 0);
    end
    data_valid = 1'b0; overrun_clr = 1'b0;
    repeat (2) tick_clk();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
